// File: rtl/des_sched_pkg.sv
// Shared types and constants for the DES/UART sequencing controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package des_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_e;

    localparam int NBYTES = 8;
    localparam int TEXT_W = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot select, registered last-grant pointer.
// Latency: select is combinational from req_i; pointer updates on the edge where adv_i is high.
// Backpressure: none; requesters hold req_i until they see a grant.
//
// Ports: clk_i/rst_i (sync, active-high), req_i[1:0] pending requests,
//        adv_i grant-taken strobe, sel_o[1:0] one-hot winner, last_o index of last winner.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] sel_o,
    output logic       last_o
);

    logic last_q;
    logic last_d;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        sel_o = 2'b00;
        case (req_i)
            2'b01:   sel_o = 2'b01;
            2'b10:   sel_o = 2'b10;
            2'b11:   sel_o = last_q ? 2'b01 : 2'b10;
            default: sel_o = 2'b00;
        endcase
        last_d = (adv_i && (sel_o != 2'b00)) ? sel_o[1] : last_q;
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/des_uart_scheduler.sv
// Shares one DES core between two requesters and streams each ciphertext to the UART, LSB byte first.
// Latency: REQ -> GRANT 1 cycle; first TX_READY 2+DES_LAT; DONE at 2+DES_LAT+8*(TX_DIV+1).
// Backpressure: requests are held until GRANT; requests arriving while BUSY wait (or are dropped if withdrawn).
//
// Ports: CLK/RST (sync, active-high); REQ[1:0], REQ_TEXT0/1 requester side;
//        GRANT, DES_CS_BAR, DES_ADDR, DES_PLAIN, DES_CIPHER DES side;
//        TX_DATA, TX_READY, TX_SRC UART side; BUSY, DONE status. All outputs registered.
module des_uart_scheduler
    import des_sched_pkg::*;
#(
    parameter int DES_LAT = 17,
    parameter int TX_DIV  = 6944
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        REQ,
    input  logic [TEXT_W-1:0] REQ_TEXT0,
    input  logic [TEXT_W-1:0] REQ_TEXT1,
    output logic [1:0]        GRANT,
    output logic              DES_CS_BAR,
    output logic              DES_ADDR,
    output logic [TEXT_W-1:0] DES_PLAIN,
    input  logic [TEXT_W-1:0] DES_CIPHER,
    output logic [7:0]        TX_DATA,
    output logic              TX_READY,
    output logic              TX_SRC,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [4:0]  LAT_LAST  = 5'(DES_LAT - 1);
    localparam logic [15:0] SLOT_LAST = 16'(TX_DIV);
    localparam logic [2:0]  BYTE_LAST = 3'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [4:0]        wait_q, wait_d;
    logic [15:0]       slot_q, slot_d;
    logic [2:0]        byte_q, byte_d;
    logic [TEXT_W-1:0] shreg_q, shreg_d;
    logic [1:0]        grant_q, grant_d;
    logic              cs_bar_q, cs_bar_d;
    logic [TEXT_W-1:0] plain_q, plain_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_rdy_q, tx_rdy_d;
    logic              src_q, src_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        arb_sel;
    logic              arb_adv;
    logic              last_grant;

    rr_arbiter2 u_arb (
        .clk_i  (CLK),
        .rst_i  (RST),
        .req_i  (REQ),
        .adv_i  (arb_adv),
        .sel_o  (arb_sel),
        .last_o (last_grant)
    );

    // Registered strobes (GRANT, DES_CS_BAR, TX_READY, DONE) are set on the
    // edge that enters the cycle in which they must be visible.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        slot_d    = slot_q;
        byte_d    = byte_q;
        shreg_d   = shreg_q;
        plain_d   = plain_q;
        tx_data_d = tx_data_q;
        src_d     = src_q;
        grant_d   = 2'b00;
        cs_bar_d  = 1'b1;
        tx_rdy_d  = 1'b0;
        done_d    = 1'b0;
        arb_adv   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_sel != 2'b00) begin
                    arb_adv  = 1'b1;
                    grant_d  = arb_sel;
                    cs_bar_d = 1'b0;
                    plain_d  = arb_sel[1] ? REQ_TEXT1 : REQ_TEXT0;
                    src_d    = arb_sel[1];
                    state_d  = START;
                end
            end
            START: begin
                wait_d  = 5'd0;
                state_d = WAIT;
            end
            WAIT: begin
                wait_d = wait_q + 5'd1;
                if (wait_q == LAT_LAST) begin
                    shreg_d   = DES_CIPHER;
                    byte_d    = 3'd0;
                    slot_d    = 16'd0;
                    tx_rdy_d  = 1'b1;
                    tx_data_d = DES_CIPHER[7:0];
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d  = 16'd0;
                    shreg_d = shreg_q >> 8;
                    if (byte_q == BYTE_LAST) begin
                        byte_d  = 3'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Next byte is the one about to shift into [7:0].
                        byte_d    = byte_q + 3'd1;
                        tx_rdy_d  = 1'b1;
                        tx_data_d = shreg_q[15:8];
                    end
                end else begin
                    slot_d = slot_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            wait_q    <= 5'd0;
            slot_q    <= 16'd0;
            byte_q    <= 3'd0;
            shreg_q   <= '0;
            grant_q   <= 2'b00;
            cs_bar_q  <= 1'b1;
            plain_q   <= '0;
            tx_data_q <= 8'd0;
            tx_rdy_q  <= 1'b0;
            src_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            slot_q    <= slot_d;
            byte_q    <= byte_d;
            shreg_q   <= shreg_d;
            grant_q   <= grant_d;
            cs_bar_q  <= cs_bar_d;
            plain_q   <= plain_d;
            tx_data_q <= tx_data_d;
            tx_rdy_q  <= tx_rdy_d;
            src_q     <= src_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The arbiter pointer and TX_SRC are both loaded from the same grant; they must agree in START.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == START) begin
            assert (last_grant == src_q);
        end
    end

    assign GRANT      = grant_q;
    assign DES_CS_BAR = cs_bar_q;
    assign DES_ADDR   = 1'b0;
    assign DES_PLAIN  = plain_q;
    assign TX_DATA    = tx_data_q;
    assign TX_READY   = tx_rdy_q;
    assign TX_SRC     = src_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_des_uart_scheduler.sv
// Directed bench for des_uart_scheduler with a cycle-exact DES model (returns ~plain 17 cycles after start).
// Latency: n/a.
// Backpressure: n/a.
module tb_des_uart_scheduler;

    localparam int DLAT    = 17;
    localparam int TDIV    = 3;
    localparam int PER     = TDIV + 1;
    localparam int T_FIRST = 2 + DLAT;
    localparam int T_DONE  = 2 + DLAT + 8 * PER;
    localparam logic [63:0] JUNK = 64'hA5A5_5A5A_C3C3_3C3C;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  REQ = 2'b00;
    logic [63:0] REQ_TEXT0 = 64'd0;
    logic [63:0] REQ_TEXT1 = 64'd0;
    logic [1:0]  GRANT;
    logic        DES_CS_BAR;
    logic        DES_ADDR;
    logic [63:0] DES_PLAIN;
    logic [63:0] DES_CIPHER = JUNK;
    logic [7:0]  TX_DATA;
    logic        TX_READY;
    logic        TX_SRC;
    logic        BUSY;
    logic        DONE;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] rx_q[$];

    des_uart_scheduler #(.DES_LAT(DLAT), .TX_DIV(TDIV)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ        (REQ),
        .REQ_TEXT0  (REQ_TEXT0),
        .REQ_TEXT1  (REQ_TEXT1),
        .GRANT      (GRANT),
        .DES_CS_BAR (DES_CS_BAR),
        .DES_ADDR   (DES_ADDR),
        .DES_PLAIN  (DES_PLAIN),
        .DES_CIPHER (DES_CIPHER),
        .TX_DATA    (TX_DATA),
        .TX_READY   (TX_READY),
        .TX_SRC     (TX_SRC),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    // DES model: cipher is valid only in the single cycle DLAT after the start cycle.
    int          des_cnt = 0;
    logic [63:0] des_txt = 64'd0;
    always @(posedge CLK) begin
        if (!DES_CS_BAR) begin
            des_cnt <= 1;
            des_txt <= DES_PLAIN;
        end else if (des_cnt != 0) begin
            des_cnt    <= (des_cnt == DLAT) ? 0 : des_cnt + 1;
            DES_CIPHER <= (des_cnt == DLAT - 1) ? ~des_txt : JUNK;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".grant"}, 64'(GRANT), 64'd0);
        chk({tag, ".csb"},   64'(DES_CS_BAR), 64'd1);
        chk({tag, ".addr"},  64'(DES_ADDR), 64'd0);
        chk({tag, ".plain"}, DES_PLAIN, 64'd0);
        chk({tag, ".txd"},   64'(TX_DATA), 64'd0);
        chk({tag, ".rdy"},   64'(TX_READY), 64'd0);
        chk({tag, ".src"},   64'(TX_SRC), 64'd0);
        chk({tag, ".busy"},  64'(BUSY), 64'd0);
        chk({tag, ".done"},  64'(DONE), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s.i%0d.grant", tag, i), 64'(GRANT), 64'd0);
            chk($sformatf("%s.i%0d.busy", tag, i), 64'(BUSY), 64'd0);
            chk($sformatf("%s.i%0d.done", tag, i), 64'(DONE), 64'd0);
        end
    endtask

    // Entered in cycle 0 (DUT idle, REQ already driven). Runs through the DONE
    // cycle, which doubles as cycle 0 of a back-to-back service.
    // mode 1: scramble REQ/texts while busy; mode 2: one-cycle REQ pulse while busy.
    // rst_at != 0: assert RST during that cycle, check reset state, then return
    // with REQ=10 and a new TEXT1 driven.
    task automatic serve(input string nm, input logic [1:0] g, input logic [63:0] txt,
                         input logic [1:0] req_after, input int mode, input int rst_at);
        logic [63:0] ciph;
        logic [63:0] sh;
        int          k;
        bit          rdy_exp;
        ciph = ~txt;
        rx_q.delete();
        for (int c = 1; c <= T_DONE; c++) begin
            tick();
            if (c == 1) REQ = req_after;
            if (mode == 1 && c >= 5 && c <= 44) begin
                REQ       = (c % 2 == 1) ? 2'b11 : 2'b10;
                REQ_TEXT0 = {32'(c), 32'hDEAD_0000};
                REQ_TEXT1 = {32'hBEEF_0000, 32'(c)};
            end
            if (mode == 1 && c == 45) REQ = req_after;
            if (mode == 2 && c == 20) REQ = 2'b10;
            if (mode == 2 && c == 21) REQ = req_after;

            rdy_exp = (c >= T_FIRST) && (c <= T_FIRST + 7 * PER) && ((c - T_FIRST) % PER == 0);
            chk($sformatf("%s.c%0d.grant", nm, c), 64'(GRANT), (c == 1) ? 64'(g) : 64'd0);
            chk($sformatf("%s.c%0d.csb", nm, c), 64'(DES_CS_BAR), (c == 1) ? 64'd0 : 64'd1);
            chk($sformatf("%s.c%0d.addr", nm, c), 64'(DES_ADDR), 64'd0);
            chk($sformatf("%s.c%0d.plain", nm, c), DES_PLAIN, txt);
            chk($sformatf("%s.c%0d.src", nm, c), 64'(TX_SRC), 64'(g[1]));
            chk($sformatf("%s.c%0d.rdy", nm, c), 64'(TX_READY), 64'(rdy_exp));
            chk($sformatf("%s.c%0d.busy", nm, c), 64'(BUSY), (c < T_DONE) ? 64'd1 : 64'd0);
            chk($sformatf("%s.c%0d.done", nm, c), 64'(DONE), (c == T_DONE) ? 64'd1 : 64'd0);
            if (c >= T_FIRST) begin
                k  = (c - T_FIRST) / PER;
                if (k > 7) k = 7;
                sh = ciph >> (8 * k);
                chk($sformatf("%s.c%0d.txd", nm, c), 64'(TX_DATA), 64'(sh[7:0]));
            end
            if (TX_READY) rx_q.push_back(TX_DATA);
            if (DONE) done_cnt++;
            if (c == rst_at) begin
                RST = 1'b1;
                tick();
                check_reset({nm, ".rst"});
                RST       = 1'b0;
                REQ       = 2'b10;
                REQ_TEXT1 = 64'h1122_3344_5566_7788;
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] exp_bytes [8];
        exp_bytes = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

        // Power-on reset state.
        tick();
        do_reset("por");

        // Single request from requester 0.
        REQ       = 2'b01;
        REQ_TEXT0 = 64'h0123_4567_89AB_CDEF;
        serve("single", 2'b01, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0);
        chk("single.nbytes", 64'(rx_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++)
            chk($sformatf("single.byte%0d", i), 64'(rx_q[i]), 64'(exp_bytes[i]));
        idle("single.after", 4);

        // Tie held high: 01, 10, 01 back to back with zero idle gap.
        do_reset("rr.rst");
        REQ       = 2'b11;
        REQ_TEXT0 = 64'hFFFF_0000_1234_5678;
        REQ_TEXT1 = 64'h0F0F_F0F0_A5A5_5A5A;
        serve("rr0", 2'b01, 64'hFFFF_0000_1234_5678, 2'b11, 0, 0);
        serve("rr1", 2'b10, 64'h0F0F_F0F0_A5A5_5A5A, 2'b11, 0, 0);
        serve("rr2", 2'b01, 64'hFFFF_0000_1234_5678, 2'b00, 0, 0);
        idle("rr.after", 4);

        // Inputs scrambled while busy must not disturb the running job.
        REQ       = 2'b01;
        REQ_TEXT0 = 64'h8000_0000_0000_0001;
        serve("meddle", 2'b01, 64'h8000_0000_0000_0001, 2'b00, 1, 0);
        idle("meddle.after", 4);

        // One-cycle request while busy is never served.
        done_cnt  = 0;
        REQ       = 2'b01;
        REQ_TEXT0 = 64'h0000_0000_0000_0000;
        serve("pulse", 2'b01, 64'h0000_0000_0000_0000, 2'b00, 2, 0);
        idle("pulse.after", 8);
        chk("pulse.done_cnt", 64'(done_cnt), 64'd1);

        // Reset in the middle of SEND, then a fresh request from requester 1.
        REQ       = 2'b01;
        REQ_TEXT0 = 64'hCAFE_BABE_DEAD_BEEF;
        serve("midrst", 2'b01, 64'hCAFE_BABE_DEAD_BEEF, 2'b00, 0, 30);
        serve("postrst", 2'b10, 64'h1122_3344_5566_7788, 2'b00, 0, 0);
        chk("postrst.nbytes", 64'(rx_q.size()), 64'd8);
        idle("postrst.after", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
